// File: rtl/decode_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU control codes and the decoded
// bundle handed from decode to execute.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] CTL_AND  = 5'd0;
    localparam logic [4:0] CTL_OR   = 5'd1;
    localparam logic [4:0] CTL_ADD  = 5'd2;
    localparam logic [4:0] CTL_XOR  = 5'd3;
    localparam logic [4:0] CTL_SLL  = 5'd4;
    localparam logic [4:0] CTL_SRL  = 5'd5;
    localparam logic [4:0] CTL_SUB  = 5'd6;
    localparam logic [4:0] CTL_SLT  = 5'd7;
    localparam logic [4:0] CTL_SLTU = 5'd13;
    localparam logic [4:0] CTL_SRA  = 5'd15;
    localparam logic [4:0] CTL_MUL  = 5'd16;
    localparam logic [4:0] CTL_NONE = 5'd31;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // The immediate is kept at its 32-bit encoded width; consumers sign-extend to XLEN.
    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  ctl;
        logic        src_imm;
        logic        src_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_bundle_t;

    localparam int DEC_BUNDLE_W = $bits(dec_bundle_t);

    function automatic logic [31:0] build_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    // Register-register / register-immediate ALU op selected by funct3 alone.
    function automatic logic [4:0] base_alu_ctl(input logic [2:0] funct3);
        logic [4:0] ctl;
        case (funct3)
            3'd0:    ctl = CTL_ADD;
            3'd1:    ctl = CTL_SLL;
            3'd2:    ctl = CTL_SLT;
            3'd3:    ctl = CTL_SLTU;
            3'd4:    ctl = CTL_XOR;
            3'd5:    ctl = CTL_SRL;
            3'd6:    ctl = CTL_OR;
            default: ctl = CTL_AND;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I(+M) instruction decoder producing a packed decode bundle.
module decode_comb
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]             instr,
    output logic [DEC_BUNDLE_W-1:0] bundle
);

    dec_bundle_t d;
    imm_fmt_e    fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        writes;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        illegal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        d        = '0;
        fmt      = IMM_NONE;
        writes   = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        d.ctl    = CTL_ADD;
        d.funct3 = f3;

        case (opcode)
            OPC_LUI: begin
                fmt       = IMM_U;
                writes    = 1'b1;
                d.src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                fmt       = IMM_U;
                writes    = 1'b1;
                d.src_imm = 1'b1;
                d.src_pc  = 1'b1;
            end
            OPC_JAL: begin
                fmt       = IMM_J;
                writes    = 1'b1;
                d.src_imm = 1'b1;
                d.src_pc  = 1'b1;
                d.jump    = 1'b1;
            end
            OPC_JALR: begin
                fmt       = IMM_I;
                writes    = 1'b1;
                uses_rs1  = 1'b1;
                d.src_imm = 1'b1;
                d.jump    = 1'b1;
                illegal   = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                fmt      = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                d.branch = 1'b1;
                case (f3)
                    3'd0, 3'd1: d.ctl = CTL_SUB;
                    3'd4, 3'd5: d.ctl = CTL_SLT;
                    3'd6, 3'd7: d.ctl = CTL_SLTU;
                    default:    illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt        = IMM_I;
                writes     = 1'b1;
                uses_rs1   = 1'b1;
                d.src_imm  = 1'b1;
                d.mem_read = 1'b1;
                illegal    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                fmt         = IMM_S;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                d.src_imm   = 1'b1;
                d.mem_write = 1'b1;
                illegal     = (f3 > 3'd2);
            end
            OPC_OPIMM: begin
                fmt       = IMM_I;
                writes    = 1'b1;
                uses_rs1  = 1'b1;
                d.src_imm = 1'b1;
                d.ctl     = base_alu_ctl(f3);
                // Shift-immediates reuse funct7 as an opcode extension, not as immediate bits.
                if (f3 == 3'd1) begin
                    illegal = (f7 != F7_BASE);
                end else if (f3 == 3'd5) begin
                    if (f7 == F7_ALT) begin
                        d.ctl = CTL_SRA;
                    end else if (f7 != F7_BASE) begin
                        illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                writes   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (f7 == F7_BASE) begin
                    d.ctl = base_alu_ctl(f3);
                end else if (f7 == F7_ALT && f3 == 3'd0) begin
                    d.ctl = CTL_SUB;
                end else if (f7 == F7_ALT && f3 == 3'd5) begin
                    d.ctl = CTL_SRA;
                end else if (f7 == F7_MULDIV && ENABLE_M) begin
                    d.ctl = CTL_MUL | {2'b00, f3};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        d.imm     = build_imm(instr, fmt);
        d.rs1     = uses_rs1 ? instr[19:15] : 5'd0;
        d.rs2     = uses_rs2 ? instr[24:20] : 5'd0;
        d.illegal = illegal;
        if (illegal) begin
            d.ctl       = CTL_NONE;
            d.mem_read  = 1'b0;
            d.mem_write = 1'b0;
            d.branch    = 1'b0;
            d.jump      = 1'b0;
        end
        d.reg_write = writes && !illegal && (instr[11:7] != 5'd0);
        d.rd        = d.reg_write ? instr[11:7] : 5'd0;
    end

    assign bundle = d;

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode in front of a two-entry skid buffer
// holding already-decoded bundles, with valid/ready on both sides and flush.
//
//  state   | meaning
//  S_EMPTY | nothing buffered, out_valid low
//  S_ONE   | output register holds a bundle, skid free
//  S_TWO   | output and skid both full, in_ready low
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int CTL_W    = 5,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [CTL_W-1:0] out_ctl,
    output logic             out_src_imm,
    output logic             out_src_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_illegal
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } buf_state_e;

    buf_state_e              state, state_nxt;
    logic [DEC_BUNDLE_W-1:0] dec_bits;
    dec_bundle_t             dec;
    dec_bundle_t             out_b;
    dec_bundle_t             skid_b;
    logic [XLEN-1:0]         out_pc_q;
    logic [XLEN-1:0]         skid_pc;
    logic                    in_ready_q;
    logic                    accept;
    logic                    emit;
    logic                    load_out_in;
    logic                    load_out_skid;
    logic                    load_skid;

    decode_comb #(.ENABLE_M(ENABLE_M)) u_decode_comb (
        .instr  (in_instr),
        .bundle (dec_bits)
    );

    assign dec    = dec_bundle_t'(dec_bits);
    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid && out_ready;

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        load_out_in = 1'b1;
                        state_nxt   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && emit) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = S_TWO;
                    end else if (emit) begin
                        state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (emit) begin
                        load_out_skid = 1'b1;
                        state_nxt     = S_ONE;
                    end
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b0;
            out_b      <= '0;
            out_pc_q   <= '0;
            skid_b     <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_TWO);
            if (load_out_in) begin
                out_b    <= dec;
                out_pc_q <= in_pc;
            end else if (load_out_skid) begin
                out_b    <= skid_b;
                out_pc_q <= skid_pc;
            end
            if (load_skid) begin
                skid_b  <= dec;
                skid_pc <= in_pc;
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state != S_EMPTY);
    assign out_pc        = out_pc_q;
    assign out_imm       = XLEN'($signed(out_b.imm));
    assign out_ctl       = CTL_W'(out_b.ctl);
    assign out_src_imm   = out_b.src_imm;
    assign out_src_pc    = out_b.src_pc;
    assign out_rs1       = out_b.rs1;
    assign out_rs2       = out_b.rs2;
    assign out_rd        = out_b.rd;
    assign out_funct3    = out_b.funct3;
    assign out_reg_write = out_b.reg_write;
    assign out_mem_read  = out_b.mem_read;
    assign out_mem_write = out_b.mem_write;
    assign out_branch    = out_b.branch;
    assign out_jump      = out_b.jump;
    assign out_illegal   = out_b.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M disabled / enabled) share stimulus and
// are compared every cycle against an instruction-level reference model and queue.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int CTL_W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;

    logic [1:0]             in_ready, out_valid, out_src_imm, out_src_pc;
    logic [1:0]             out_reg_write, out_mem_read, out_mem_write;
    logic [1:0]             out_branch, out_jump, out_illegal;
    logic [1:0][XLEN-1:0]   out_pc, out_imm;
    logic [1:0][CTL_W-1:0]  out_ctl;
    logic [1:0][4:0]        out_rs1, out_rs2, out_rd;
    logic [1:0][2:0]        out_funct3;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .CTL_W(CTL_W), .ENABLE_M(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_pc(out_pc[0]), .out_imm(out_imm[0]), .out_ctl(out_ctl[0]),
        .out_src_imm(out_src_imm[0]), .out_src_pc(out_src_pc[0]), .out_rs1(out_rs1[0]),
        .out_rs2(out_rs2[0]), .out_rd(out_rd[0]), .out_funct3(out_funct3[0]),
        .out_reg_write(out_reg_write[0]), .out_mem_read(out_mem_read[0]),
        .out_mem_write(out_mem_write[0]), .out_branch(out_branch[0]), .out_jump(out_jump[0]),
        .out_illegal(out_illegal[0])
    );

    decode_stage #(.XLEN(XLEN), .CTL_W(CTL_W), .ENABLE_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_pc(out_pc[1]), .out_imm(out_imm[1]), .out_ctl(out_ctl[1]),
        .out_src_imm(out_src_imm[1]), .out_src_pc(out_src_pc[1]), .out_rs1(out_rs1[1]),
        .out_rs2(out_rs2[1]), .out_rd(out_rd[1]), .out_funct3(out_funct3[1]),
        .out_reg_write(out_reg_write[1]), .out_mem_read(out_mem_read[1]),
        .out_mem_write(out_mem_write[1]), .out_branch(out_branch[1]), .out_jump(out_jump[1]),
        .out_illegal(out_illegal[1])
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  ctl;
        logic        src_imm;
        logic        src_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        ill;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   emitted = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic rst_prev = 1'b1;

    function automatic exp_t actual(input int k);
        exp_t a;
        a = '{pc: out_pc[k], imm: out_imm[k], ctl: out_ctl[k], src_imm: out_src_imm[k],
              src_pc: out_src_pc[k], rs1: out_rs1[k], rs2: out_rs2[k], rd: out_rd[k],
              f3: out_funct3[k], rw: out_reg_write[k], mr: out_mem_read[k],
              mw: out_mem_write[k], br: out_branch[k], jp: out_jump[k], ill: out_illegal[k]};
        return a;
    endfunction

    // Mnemonic-level reference: what the ISA says each encoding means.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input bit m);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          wr, r1, r2;
        logic [31:0] ii, si, bi, ui, ji;
        logic [4:0]  arith [8];
        arith = '{5'd2, 5'd4, 5'd7, 5'd13, 5'd3, 5'd5, 5'd1, 5'd0};
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        ii = 32'($signed(i[31:20]));
        si = 32'($signed({i[31:25], i[11:7]}));
        bi = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        ui = {i[31:12], 12'h000};
        ji = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        e = '0;
        e.pc = pc;
        e.f3 = f3;
        e.ctl = 5'd2;
        wr = 0; r1 = 0; r2 = 0;
        case (op)
            7'h37: begin e.imm = ui; e.src_imm = 1; wr = 1; end
            7'h17: begin e.imm = ui; e.src_imm = 1; e.src_pc = 1; wr = 1; end
            7'h6F: begin e.imm = ji; e.src_imm = 1; e.src_pc = 1; e.jp = 1; wr = 1; end
            7'h67: begin e.imm = ii; e.src_imm = 1; e.jp = 1; wr = 1; r1 = 1; e.ill = (f3 != 0); end
            7'h63: begin
                e.imm = bi; e.br = 1; r1 = 1; r2 = 1;
                if (f3 == 2 || f3 == 3) e.ill = 1;
                else e.ctl = (f3 < 2) ? 5'd6 : (f3 < 6) ? 5'd7 : 5'd13;
            end
            7'h03: begin
                e.imm = ii; e.src_imm = 1; e.mr = 1; wr = 1; r1 = 1;
                e.ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin e.imm = si; e.src_imm = 1; e.mw = 1; r1 = 1; r2 = 1; e.ill = (f3 > 2); end
            7'h13: begin
                e.imm = ii; e.src_imm = 1; wr = 1; r1 = 1; e.ctl = arith[f3];
                if (f3 == 1 && f7 != 0) e.ill = 1;
                if (f3 == 5 && f7 == 7'h20) e.ctl = 5'd15;
                else if (f3 == 5 && f7 != 0) e.ill = 1;
            end
            7'h33: begin
                wr = 1; r1 = 1; r2 = 1;
                if (f7 == 0) e.ctl = arith[f3];
                else if (f7 == 7'h20 && f3 == 0) e.ctl = 5'd6;
                else if (f7 == 7'h20 && f3 == 5) e.ctl = 5'd15;
                else if (f7 == 7'h01 && m) e.ctl = 5'(16 + int'(f3));
                else e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        e.rs1 = r1 ? i[19:15] : 5'd0;
        e.rs2 = r2 ? i[24:20] : 5'd0;
        if (e.ill) begin
            e.ctl = 5'd31; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
        end
        e.rw = wr && !e.ill && (i[11:7] != 0);
        e.rd = e.rw ? i[11:7] : 5'd0;
        return e;
    endfunction

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Per-cycle scoreboard; inputs change only just after posedge, so negedge sees them settled.
    always @(negedge clk) begin
        bit exp_ready;
        exp_ready = !rst_prev && (q0.size() < 2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (in_ready[k] !== exp_ready || out_valid[k] !== (q0.size() != 0)) begin
                errors++;
                $display("FAIL flow[%0d] @%0t: in_ready %b out_valid %b expected %b %b",
                         k, $time, in_ready[k], out_valid[k], exp_ready, q0.size() != 0);
            end
        end
        if (out_valid[0] && q0.size() != 0) begin
            checks++;
            if (actual(0) !== q0[0]) begin
                errors++;
                $display("FAIL bundle_m0 @%0t: got %h expected %h", $time, actual(0), q0[0]);
            end
            checks++;
            if (actual(1) !== q1[0]) begin
                errors++;
                $display("FAIL bundle_m1 @%0t: got %h expected %h", $time, actual(1), q1[0]);
            end
        end
        if (rst || flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (out_valid[0] && out_ready && q0.size() != 0) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                emitted++;
            end
            if (in_valid && in_ready[0]) begin
                q0.push_back(model(in_instr, in_pc, 1'b0));
                q1.push_back(model(in_instr, in_pc, 1'b1));
            end
        end
        rst_prev = rst;
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready[0];
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr %h never accepted", instr);
        end
        in_valid = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec [12];
    int          e0;

    initial begin
        vec = '{32'h123452B7, 32'h00001317, 32'h010000EF, 32'h00008067,
                32'h0041E463, 32'hFF812383, 32'h4030D413, 32'h402084B3,
                32'h4020D533, 32'h40309413, 32'h0000007F, 32'h0220D5B3};

        repeat (3) tick();
        @(negedge clk);
        lit("rst_out_valid", 32'(out_valid[0]), 32'h0);
        lit("rst_in_ready", 32'(in_ready[0]), 32'h0);
        lit("rst_ctl", 32'(out_ctl[0]), 32'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // addi x1,x0,-1
        send(32'hFFF00093, 32'h100);
        @(negedge clk);
        lit("addi_valid", 32'(out_valid[0]), 32'h1);
        lit("addi_ctl", 32'(out_ctl[0]), 32'd2);
        lit("addi_imm", out_imm[0], 32'hFFFFFFFF);
        lit("addi_src_imm", 32'(out_src_imm[0]), 32'h1);
        lit("addi_rd", 32'(out_rd[0]), 32'd1);
        lit("addi_rw", 32'(out_reg_write[0]), 32'h1);
        tick();

        // sltiu x2,x1,5
        send(32'h0050B113, 32'h104);
        @(negedge clk);
        lit("sltiu_ctl", 32'(out_ctl[0]), 32'd13);
        lit("sltiu_imm", out_imm[0], 32'd5);
        lit("sltiu_rs1", 32'(out_rs1[0]), 32'd1);
        lit("sltiu_rd", 32'(out_rd[0]), 32'd2);
        tick();

        // sw x2,8(x1)
        send(32'h0020A423, 32'h108);
        @(negedge clk);
        lit("sw_imm", out_imm[0], 32'd8);
        lit("sw_mem_write", 32'(out_mem_write[0]), 32'h1);
        lit("sw_rd", 32'(out_rd[0]), 32'd0);
        lit("sw_rw", 32'(out_reg_write[0]), 32'h0);
        tick();

        // mul x3,x1,x2
        send(32'h022081B3, 32'h10C);
        @(negedge clk);
        lit("mul_m0_illegal", 32'(out_illegal[0]), 32'h1);
        lit("mul_m0_ctl", 32'(out_ctl[0]), 32'd31);
        lit("mul_m0_rw", 32'(out_reg_write[0]), 32'h0);
        lit("mul_m1_ctl", 32'(out_ctl[1]), 32'd16);
        lit("mul_m1_rw", 32'(out_reg_write[1]), 32'h1);
        tick();

        // beq x1,x2,-4
        send(32'hFE208EE3, 32'h110);
        @(negedge clk);
        lit("beq_imm", out_imm[0], 32'hFFFFFFFC);
        lit("beq_ctl", 32'(out_ctl[0]), 32'd6);
        lit("beq_branch", 32'(out_branch[0]), 32'h1);
        lit("beq_src_imm", 32'(out_src_imm[0]), 32'h0);
        tick();

        // Streaming vectors back to back; checked by the scoreboard.
        foreach (vec[n]) send(vec[n], 32'h200 + 32'(n * 4));
        repeat (3) tick();

        // Stall: two accepted, third blocked, then released in order.
        e0 = emitted;
        out_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200113, 32'h304);
        @(negedge clk);
        lit("stall_in_ready", 32'(in_ready[0]), 32'h0);
        lit("stall_head_pc", out_pc[0], 32'h300);
        tick();
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 32'h308;
        @(negedge clk);
        lit("stall_blocked", 32'(in_ready[0]), 32'h0);
        tick();
        out_ready = 1'b1;
        send(32'h00300193, 32'h308);
        repeat (6) tick();
        lit("stall_emitted", 32'(emitted - e0), 32'd3);

        // Flush while full with a new instruction offered.
        e0 = emitted;
        out_ready = 1'b0;
        send(32'h00400213, 32'h400);
        send(32'h00500293, 32'h404);
        in_valid = 1'b1;
        in_instr = 32'h00600313;
        in_pc    = 32'h408;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        lit("flush_out_valid", 32'(out_valid[0]), 32'h0);
        lit("flush_in_ready", 32'(in_ready[0]), 32'h1);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();
        lit("flush_emitted", 32'(emitted - e0), 32'd0);

        // Reset mid-stream with a bundle held at the output.
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h500);
        @(negedge clk);
        lit("prerst_valid", 32'(out_valid[0]), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (actual(0) !== exp_t'('0) || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: got %h valid %b expected all zero", actual(0), out_valid[0]);
        end
        lit("rst_in_ready_low", 32'(in_ready[0]), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        lit("rst_release_ready_low", 32'(in_ready[0]), 32'h0);
        tick();
        @(negedge clk);
        lit("rst_release_ready_high", 32'(in_ready[0]), 32'h1);
        tick();
        out_ready = 1'b1;
        send(32'h0050B113, 32'h600);
        repeat (3) tick();
        lit("final_queue_empty", 32'(q0.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
